// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Drains a byte-wide synchronous FIFO and packs PACK_RATIO consecutive bytes
// into one little-endian word (first byte read lands in lane 0). The packed
// word is presented on a valid/ready handshake. A flush pulse emits whatever
// bytes are currently held as a partial word, with unused upper lanes zeroed.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   fifo_empty FIFO empty flag
//   rd_vld     FIFO read data valid, one cycle after an accepted rd_en
//   fifo_data  FIFO read data
//   rd_en      FIFO read request (combinational from registered state)
//   flush      single-cycle request to emit the held bytes as a partial word
//   out_valid  packed word valid
//   out_ready  downstream accept
//   out_data   packed word, byte k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   out_bytes  number of valid bytes in out_data (1..PACK_RATIO)
//   err        sticky: rd_vld seen while no read was in flight
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic                             rd_vld,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             rd_en,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [CNT_WIDTH-1:0]             out_bytes,
    output logic                             err
);

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        EMIT       = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_RATIO);
    localparam logic [CNT_WIDTH:0]   FULL_SUM = (CNT_WIDTH + 1)'(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Registered state
    state_t                                    state_r;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]     acc_r;
    logic [CNT_WIDTH-1:0]                      count_r;
    logic                                      inflight_r;
    logic                                      flush_pend_r;
    logic                                      out_valid_r;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]     out_data_r;
    logic [CNT_WIDTH-1:0]                      out_bytes_r;
    logic                                      err_r;

    // Next-state values
    state_t                                    state_next_s;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]     acc_next_s;
    logic [CNT_WIDTH-1:0]                      count_next_s;
    logic                                      flush_pend_next_s;
    logic                                      out_valid_next_s;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]     out_data_next_s;
    logic [CNT_WIDTH-1:0]                      out_bytes_next_s;
    logic                                      err_next_s;
    logic                                      out_free_s;
    logic                                      emit_s;
    logic                                      capture_s;
    logic [CNT_WIDTH:0]                        pending_sum_s;

    // Bytes held plus the byte still on its way must leave room in acc.
    assign pending_sum_s = {1'b0, count_r} + {{CNT_WIDTH{1'b0}}, inflight_r};
    assign rd_en = !rst && !fifo_empty && !flush_pend_r && (pending_sum_s < FULL_SUM);

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_bytes = out_bytes_r;
    assign err       = err_r;

    // Next-state and datapath decode: capture, emit, flush bookkeeping, FSM.
    always_comb begin
        acc_next_s        = acc_r;
        count_next_s      = count_r;
        flush_pend_next_s = flush_pend_r;
        out_data_next_s   = out_data_r;
        out_bytes_next_s  = out_bytes_r;
        out_valid_next_s  = out_valid_r;
        err_next_s        = err_r;
        state_next_s      = FILL;

        // The output register counts as free in the cycle it is accepted.
        out_free_s = !out_valid_r || out_ready;
        emit_s     = (state_r == EMIT) && out_free_s;
        // A byte arriving with acc already full is dropped.
        capture_s  = rd_vld && (count_r < FULL_CNT);

        if (rd_vld && !inflight_r) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_r;
        end

        if (out_valid_r && out_ready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end

        if (emit_s) begin
            for (int k = 0; k < PACK_RATIO; k++) begin
                if (CNT_WIDTH'(k) < count_r) begin
                    out_data_next_s[k] = acc_r[k];
                end else begin
                    out_data_next_s[k] = {DATA_WIDTH{1'b0}};
                end
            end
            out_bytes_next_s  = count_r;
            out_valid_next_s  = 1'b1;
            flush_pend_next_s = 1'b0;
            // Only a stray (unrequested) byte can coincide with an emit;
            // it starts the next word in lane 0.
            if (capture_s) begin
                acc_next_s[0] = fifo_data;
                count_next_s  = CNT_ONE;
            end else begin
                count_next_s  = CNT_ZERO;
            end
        end else begin
            if (capture_s) begin
                for (int k = 0; k < PACK_RATIO; k++) begin
                    if (count_r == CNT_WIDTH'(k)) begin
                        acc_next_s[k] = fifo_data;
                    end else begin
                        acc_next_s[k] = acc_r[k];
                    end
                end
                count_next_s = count_r + CNT_ONE;
            end else begin
                count_next_s = count_r;
            end
            // Nothing held and nothing in flight: no empty word is produced.
            if (flush && ((count_r != CNT_ZERO) || inflight_r)) begin
                flush_pend_next_s = 1'b1;
            end else begin
                flush_pend_next_s = flush_pend_r;
            end
        end

        // rd_en is the next value of inflight.
        if ((count_next_s == FULL_CNT) ||
            (flush_pend_next_s && (count_next_s != CNT_ZERO) && !rd_en)) begin
            state_next_s = EMIT;
        end else if (flush_pend_next_s) begin
            state_next_s = FLUSH_WAIT;
        end else begin
            state_next_s = FILL;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FILL;
            acc_r        <= {(DATA_WIDTH*PACK_RATIO){1'b0}};
            count_r      <= CNT_ZERO;
            inflight_r   <= 1'b0;
            flush_pend_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {(DATA_WIDTH*PACK_RATIO){1'b0}};
            out_bytes_r  <= CNT_ZERO;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            acc_r        <= acc_next_s;
            count_r      <= count_next_s;
            inflight_r   <= rd_en;
            flush_pend_r <= flush_pend_next_s;
            out_valid_r  <= out_valid_next_s;
            out_data_r   <= out_data_next_s;
            out_bytes_r  <= out_bytes_next_s;
            err_r        <= err_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Bench for fifo_word_packer (8-bit lanes, 4 bytes per word). A small FIFO
// model answers rd_en with rd_vld one cycle later. Every word accepted
// downstream is logged and compared against a table of expected words;
// multi-cycle corner cases are checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        rd_vld = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        rd_en;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        err;

    logic        inj_vld = 1'b0;
    logic [7:0]  inj_data = 8'h00;
    logic [7:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          rel1;
    int          n_cmp = 0;
    int          n_bad = 0;

    word_t       got_q[$];
    int          got_cyc[$];
    word_t       exp_tab[8];

    fifo_word_packer #(
        .DATA_WIDTH(8),
        .PACK_RATIO(4),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .rd_vld(rd_vld),
        .fifo_data(fifo_data),
        .rd_en(rd_en),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_bytes(out_bytes),
        .err(err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: data and rd_vld one cycle after an accepted rd_en.
    always @(posedge clk) begin
        if (rd_en && (wr_ptr != rd_ptr)) begin
            rd_vld    <= 1'b1;
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            rd_vld    <= inj_vld;
            fifo_data <= inj_data;
        end
    end

    // Log every accepted output word with its cycle stamp.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back('{out_data, out_bytes});
            got_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // One reset cycle; returns at the negedge after it with rst low.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rd_en_in_reset", 32'(rd_en), 32'd0);
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        exp_tab[0] = '{32'h03020100, 3'd4};
        exp_tab[1] = '{32'h07060504, 3'd4};
        exp_tab[2] = '{32'h00002211, 3'd2};
        exp_tab[3] = '{32'hA3A2A1A0, 3'd4};
        exp_tab[4] = '{32'hA7A6A5A4, 3'd4};
        exp_tab[5] = '{32'h00333231, 3'd3};
        exp_tab[6] = '{32'h63626160, 3'd4};
        exp_tab[7] = '{32'h00000077, 3'd1};

        // 1: two full words back to back
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'(i));
        out_ready = 1'b1;
        do_reset();
        rel1 = cyc;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_bytes", 32'(out_bytes), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick(5);
        chk("t1_rd_en_full", 32'(rd_en), 32'd0);
        chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("t1_valid_latency", 32'(out_valid), 32'd1);
        tick(10);
        chk("t1_err", 32'(err), 32'd0);

        // 2: flush after two captured bytes
        do_reset();
        push(8'h11);
        push(8'h22);
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(6);
        chk("t2_rd_en_idle", 32'(rd_en), 32'd0);
        chk("t2_out_valid_idle", 32'(out_valid), 32'd0);

        // 3: backpressure, acc fills behind a held word
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
        tick(16);
        chk("t3_rd_en_blocked", 32'(rd_en), 32'd0);
        chk("t3_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        chk("t3_held_valid", 32'(out_valid), 32'd1);
        chk("t3_held_data", out_data, 32'hA3A2A1A0);
        chk("t3_held_bytes", 32'(out_bytes), 32'd4);
        out_ready = 1'b1;
        tick(1);
        chk("t3_next_valid", 32'(out_valid), 32'd1);
        chk("t3_next_data", out_data, 32'hA7A6A5A4);
        tick(6);

        // 4: flush alongside the read of the third byte
        do_reset();
        push(8'h31);
        push(8'h32);
        push(8'h33);
        push(8'h34);
        tick(2);
        flush = 1'b1;
        #1;
        chk("t4_rd_en_flush_cycle", 32'(rd_en), 32'd1);
        tick(1);
        flush = 1'b0;
        #1;
        chk("t4_rd_en_stop", 32'(rd_en), 32'd0);
        tick(1);
        chk("t4_rd_en_wait", 32'(rd_en), 32'd0);
        chk("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        tick(1);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_bytes", 32'(out_bytes), 32'd3);
        tick(6);

        // 5: reset with a held word and two bytes in acc
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        tick(10);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_out_bytes", 32'(out_bytes), 32'd0);
        chk("t5_out_data", out_data, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        tick(9);

        // 6: unrequested rd_vld sets sticky err; byte still captured
        do_reset();
        inj_data = 8'h77;
        inj_vld = 1'b1;
        tick(1);
        inj_vld = 1'b0;
        chk("t6_err_before", 32'(err), 32'd0);
        tick(1);
        chk("t6_err_set", 32'(err), 32'd1);
        tick(5);
        chk("t6_err_sticky", 32'(err), 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(4);
        chk("t6_err_still", 32'(err), 32'd1);
        do_reset();
        chk("t6_err_cleared", 32'(err), 32'd0);

        // Word log against the table
        chk("word_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("word%0d_data", i), got_q[i].data, exp_tab[i].data);
                chk($sformatf("word%0d_bytes", i), 32'(got_q[i].bytes), 32'(exp_tab[i].bytes));
            end else begin
                chk($sformatf("word%0d_missing", i), 32'd0, 32'd1);
            end
        end
        if (got_cyc.size() >= 5) begin
            chk("t1_accept0_cycle", 32'(got_cyc[0] - rel1), 32'd6);
            chk("t1_accept1_cycle", 32'(got_cyc[1] - rel1), 32'd12);
            chk("t3_back_to_back", 32'(got_cyc[4] - got_cyc[3]), 32'd1);
        end else begin
            chk("accept_cycles_missing", 32'(got_cyc.size()), 32'd5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
